// File: rtl/ntt16_seq_ctrl.sv
// Sequential 16-point NTT over Z_q: loads 16 samples, walks all (i,j) terms
// through one multiply-accumulate unit, then streams X[0..15] out.
module ntt16_seq_ctrl #(
  parameter int N  = 16,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DW-1:0]        cfg_q,
  input  logic [DW-1:0]        cfg_w,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           dbg_state
);
  // Streams transfer on any rising edge where valid and ready are both high;
  // a source holds its data stable while valid is high and ready is low.
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   q_q, q_d, w_q, w_d;
  logic [DW-1:0]   acc_q, acc_d, t_q, t_d, s_q, s_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [AW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d, out_idx_q, out_idx_d;
  logic            out_valid_q, out_valid_d, done_q, done_d, err_q, err_d;

  logic [DW-1:0]   a_mem   [N];
  logic [DW-1:0]   res_mem [N];
  logic            a_we, res_we;

  logic [DW-1:0]   q_eff, one_mod, acc_nx, t_nx, s_nx;
  logic [2*DW-1:0] prod;
  logic [2*DW:0]   sum;
  logic [AW-1:0]   k_inc;

  // With q < 2 every reduction is taken mod 1, forcing all results to zero
  // without ever dividing by zero.
  always_comb begin
    q_eff   = (q_q < DW'(2)) ? DW'(1) : q_q;
    one_mod = err_q ? '0 : DW'(1);
    prod    = {{DW{1'b0}}, a_mem[j_q]} * {{DW{1'b0}}, t_q};
    sum     = {1'b0, {DW{1'b0}}, acc_q} + {1'b0, prod};
    acc_nx  = DW'(sum % {{(DW+1){1'b0}}, q_eff});
    t_nx    = DW'(({{DW{1'b0}}, t_q} * {{DW{1'b0}}, s_q}) % {{DW{1'b0}}, q_eff});
    s_nx    = DW'(({{DW{1'b0}}, s_q} * {{DW{1'b0}}, w_q}) % {{DW{1'b0}}, q_eff});
    k_inc   = k_q + AW'(1);
  end

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    w_d         = w_q;
    acc_d       = acc_q;
    t_d         = t_q;
    s_d         = s_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    err_d       = err_q;
    a_we        = 1'b0;
    res_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          q_d     = cfg_q;
          w_d     = cfg_w;
          j_d     = '0;
          err_d   = (cfg_q < DW'(2));
        end
      end
      LOAD: begin
        if (in_valid) begin
          a_we = 1'b1;
          j_d  = j_q + AW'(1);
          if (j_q == LAST) begin
            state_d = COMPUTE;
            i_d     = '0;
            j_d     = '0;
            acc_d   = '0;
            s_d     = one_mod;
            t_d     = one_mod;
          end
        end
      end
      COMPUTE: begin
        acc_d = acc_nx;
        t_d   = t_nx;
        j_d   = j_q + AW'(1);
        if (j_q == LAST) begin
          res_we = 1'b1;
          acc_d  = '0;
          t_d    = one_mod;
          s_d    = s_nx;
          i_d    = i_q + AW'(1);
          if (i_q == LAST) begin
            state_d     = DRAIN;
            k_d         = '0;
            out_valid_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // First DRAIN cycle primes the output register; the done cycle is
        // spent in DRAIN so a start coinciding with done is not seen.
        if (done_q) begin
          state_d = IDLE;
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = res_mem[k_q];
          out_idx_d   = k_q;
        end else if (out_ready) begin
          if (k_q == LAST) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            k_d         = '0;
          end else begin
            k_d        = k_inc;
            out_data_d = res_mem[k_inc];
            out_idx_d  = k_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      w_q         <= '0;
      acc_q       <= '0;
      t_q         <= '0;
      s_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      w_q         <= w_d;
      acc_q       <= acc_d;
      t_q         <= t_d;
      s_q         <= s_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Sample and result buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (a_we)   a_mem[j_q]   <= in_data;
    if (res_we) res_mem[i_q] <= acc_nx;
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;
endmodule
